instr_redirect_ctrl: RTL

- Parametrised, registered successor to the two-bit instruction force/OR stage between decode and the jump/branch path.
- Merges the sequential instruction stream with NCH prioritised jump-redirect channels.
- Applies a global force (all-ones override) and inserts a fixed-length NOP flush window after each taken redirect.
- Queues one redirect that arrives during a flush.

---
 rtl/instr_redirect_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_redirect_ctrl.sv
// instr_redirect_ctrl
//   Registered instruction merge stage between decode and the jump/branch
//   path. Passes the sequential instruction stream through, takes
//   prioritised redirects from NCH channels (channel 0 highest), follows
//   every taken redirect with FLUSH_CYC NOP cycles, and parks at most one
//   redirect that arrives during a flush. force_en ORs all-ones onto every
//   emitted code.
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   synchronous active-low reset
//   stall         in   hold all state and outputs
//   force_en      in   OR all-ones onto the emitted code
//   instr_in      in   [IW]      sequential instruction code
//   jmp_req       in   [NCH]     per-channel redirect request pulse
//   jmp_instr     in   [NCH*IW]  redirect codes, channel i at [i*IW +: IW]
//   ovr_clr       in   clear the sticky overrun flag
//   instr_checked out  [IW]      registered instruction code
//   flush         out  NOP flush cycle in progress
//   src_ch        out  [CW]      channel of the most recently taken redirect
//   busy          out  not idle or a redirect is parked
//   overrun       out  sticky: a redirect was dropped
module instr_redirect_ctrl #(
  parameter int unsigned    IW        = 2,
  parameter int unsigned    NCH       = 2,
  parameter int unsigned    FLUSH_CYC = 2,
  parameter logic [IW-1:0]  NOP       = '0,
  localparam int unsigned   CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              force_en,
  input  logic [IW-1:0]     instr_in,
  input  logic [NCH-1:0]    jmp_req,
  input  logic [NCH*IW-1:0] jmp_instr,
  input  logic              ovr_clr,
  output logic [IW-1:0]     instr_checked,
  output logic              flush,
  output logic [CW-1:0]     src_ch,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned CNTW = 4;

  // S_DRAIN: the cycle after the last NOP when a parked redirect is emitted.
  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            pend_vld_q, pend_vld_d;
  logic [IW-1:0]   pend_code_q, pend_code_d;
  logic [CW-1:0]   pend_ch_q, pend_ch_d;
  logic            ovr_q, ovr_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic            flush_q, flush_d;
  logic [CW-1:0]   src_q, src_d;
  logic            busy_q, busy_d;

  logic            req_any;
  logic            req_extra;
  logic [CW-1:0]   req_sel;
  logic [IW-1:0]   req_code;
  logic            drop;
  logic [IW-1:0]   force_mask;

  function automatic logic [CW-1:0] lowest_idx(input logic [NCH-1:0] r);
    logic [CW-1:0] idx;
    logic          found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (r[i] && !found) begin
        idx   = CW'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  assign req_any    = |jmp_req;
  // r & (r-1) clears the lowest set bit; anything left loses arbitration.
  assign req_extra  = |(jmp_req & (jmp_req - NCH'(1)));
  assign req_sel    = lowest_idx(jmp_req);
  assign req_code   = jmp_instr[req_sel*IW +: IW];
  assign force_mask = {IW{force_en}};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_code_q <= '0;
      pend_ch_q   <= '0;
      ovr_q       <= 1'b0;
      instr_q     <= '0;
      flush_q     <= 1'b0;
      src_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_code_q <= pend_code_d;
      pend_ch_q   <= pend_ch_d;
      ovr_q       <= ovr_d;
      instr_q     <= instr_d;
      flush_q     <= flush_d;
      src_q       <= src_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_code_d = pend_code_q;
    pend_ch_d   = pend_ch_q;
    drop        = 1'b0;
    if (!stall) begin
      unique case (state_q)
        S_IDLE: begin
          if (req_any) begin
            state_d = S_FLUSH;
            cnt_d   = CNTW'(FLUSH_CYC);
            drop    = req_extra;
          end
        end
        S_FLUSH: begin
          cnt_d = cnt_q - CNTW'(1);
          if (pend_vld_q) begin
            drop = req_any;
          end else if (req_any) begin
            pend_vld_d  = 1'b1;
            pend_code_d = req_code;
            pend_ch_d   = req_sel;
            drop        = req_extra;
          end
          // A request parked on the last NOP cycle is still drained next.
          if (cnt_q == CNTW'(1)) begin
            state_d = pend_vld_d ? S_DRAIN : S_IDLE;
          end
        end
        S_DRAIN: begin
          state_d    = S_FLUSH;
          cnt_d      = CNTW'(FLUSH_CYC);
          // Slot frees this cycle, so a new request may take it straight away.
          pend_vld_d = req_any;
          if (req_any) begin
            pend_code_d = req_code;
            pend_ch_d   = req_sel;
          end
          drop = req_extra;
        end
        default: state_d = S_IDLE;
      endcase
    end
    ovr_d = stall ? ovr_q : ((ovr_q & ~ovr_clr) | drop);
  end

  // Output logic
  always_comb begin
    instr_d = instr_q;
    flush_d = flush_q;
    src_d   = src_q;
    busy_d  = busy_q;
    if (!stall) begin
      unique case (state_q)
        S_IDLE: begin
          flush_d = 1'b0;
          if (req_any) begin
            instr_d = req_code | force_mask;
            src_d   = req_sel;
          end else begin
            instr_d = instr_in | force_mask;
          end
        end
        S_FLUSH: begin
          instr_d = NOP | force_mask;
          flush_d = 1'b1;
        end
        S_DRAIN: begin
          instr_d = pend_code_q | force_mask;
          src_d   = pend_ch_q;
          flush_d = 1'b0;
        end
        default: begin
          instr_d = NOP | force_mask;
          flush_d = 1'b0;
        end
      endcase
      busy_d = (state_d != S_IDLE) | pend_vld_d;
    end
  end

  assign instr_checked = instr_q;
  assign flush         = flush_q;
  assign src_ch        = src_q;
  assign busy          = busy_q;
  assign overrun       = ovr_q;

endmodule
